sipo_deframer: RTL
==================

# sipo_deframer

Serial-in, parallel-out receiver and the mate of our parallel-to-serial shifter. It takes an LSB-first bit stream with a per-bit strobe and a start-of-word marker, and assembles DATA_WIDTH-bit words. Each completed word is presented on a valid/ready output port through a one-word holding slot. It sits at the receive end of the on-chip serial link, between the link pins/CDC stage and the word-level consumer.

## Interface
- DATA_WIDTH, 16, word width in bits; legal range 2..64.
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- din  in  1  serial data bit; LSB of each word first.
- din_vld  in  1  din carries a bit this cycle.
- din_sof  in  1  qualified by din_vld; din is bit 0 of a new word.
- dout  out  DATA_WIDTH  assembled word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout this cycle when dout_valid is high.
- misalign  out  1  one-cycle pulse: din_sof arrived mid-word.
- overflow  out  1  sticky: a completed word was dropped because the slot was full.
- ovf_clr  in  1  clears overflow; set wins if both occur in the same cycle.

## Operation
- FSM states:
  - HUNT: reset state. din_vld without din_sof is ignored. din_vld && din_sof captures din as bit 0, sets cnt=1 and moves to ASSEM.
  - ASSEM: every din_vld shifts din in (sreg <= {din, sreg[W-1:1]}) and increments cnt.
- Word completion: din_vld && !din_sof && cnt==W-1 completes a word.
  - Assembled word = {din, sreg[W-1:1]}.
  - cnt wraps to 0 and the FSM stays in ASSEM.
  - The next word needs no din_sof; back-to-back words are supported.
- Resync: din_sof in ASSEM with cnt!=0 discards the partial word, captures din as bit 0 and sets cnt=1.
  - misalign pulses for that cycle.
  - A din_sof at cnt==W-1 also counts as a resync: no word is emitted.
  - din_sof at cnt==0 is a normal word start; no pulse.
- Output slot:
  - A completed word loads dout and sets dout_valid when the slot is empty, or when it is being drained in the same cycle (dout_valid && dout_ready).
  - Otherwise the word is dropped, overflow is set and the slot keeps its old word.
- Handshake:
  - A transfer occurs on any cycle with dout_valid && dout_ready.
  - dout is stable while dout_valid && !dout_ready.
  - dout_valid falls after a transfer unless a new word loads in the same cycle.
  - dout keeps its last value when dout_valid is low.
- Bits arriving while the slot is full keep assembling; only completion checks the slot.
- din_vld low: no state change in sreg, cnt or FSM.

## Timing
- Reset values (resetn low at an edge): FSM=HUNT, cnt=0, sreg=0, dout=0, dout_valid=0, misalign=0, overflow=0.
- Latency: final bit sampled at edge k gives dout_valid=1 with the word after edge k. No combinational path from din to dout.
- dout_ready to dout_valid: registered. dout_ready has no combinational path to any output.
- misalign: registered, high exactly the cycle after the offending din_sof edge.
- Throughput: one word per W strobed bits. The slot sustains full rate if the consumer accepts within W-1 cycles.
- Reset mid-word or mid-handshake: partial and held words are lost, and the FSM returns to HUNT next cycle.

## Structure
- Package sipo_pkg holds:
  - sipo_state_e (HUNT, ASSEM).
  - The count-width function $clog2(DATA_WIDTH).
- Sub-module sipo_out_slot: one-entry valid/ready holding register with load/drop/overflow logic. The top level holds the FSM, counter and shift register.

## Test plan
- W=8, reset, then din_sof + bits of 0xA5 LSB-first, dout_ready=1 -> dout=0xA5 with dout_valid for 1 cycle, the cycle after the 8th bit; misalign=0.
- 12 strobed bits before any din_sof -> nothing emitted. Then din_sof + 0x3C -> dout=0x3C only.
- Back-to-back 0x01, 0x80, 0xFF with din_vld gaps, no further din_sof, dout_ready=1 -> three words in order, each on the cycle after its last bit.
- dout_ready=0 while 0x11 then 0x22 complete -> dout stays 0x11 and overflow=1. ovf_clr pulse -> overflow=0. The ovf_clr and completion-drop in the same cycle -> overflow stays 1.
- din_sof after 5 bits of a word, then 0x5A -> misalign pulses once, partial word discarded, dout=0x5A.
- resetn low for 1 cycle mid-word and with dout_valid=1 -> all outputs 0 next cycle. Later bits without din_sof ignored until a new din_sof.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in, parallel-out deframer.
package sipo_pkg;

  typedef enum logic {HUNT, ASSEM} sipo_state_e;

  function automatic int cnt_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry valid/ready holding register; words that complete while it is full are dropped.
module sipo_out_slot #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  dout_ready,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  overflow
);

  logic drain;
  logic accept;

  assign drain  = dout_valid && dout_ready;
  assign accept = load && (!dout_valid || dout_ready);

  // A drop only happens when the slot is full and not draining; a drop beats a clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (drain) begin
        dout_valid <= 1'b0;
      end
      if (load && !accept) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deframer.sv
// Receive-side deframer: assembles LSB-first strobed bits into words and hands them to the output slot.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_vld,
  input  logic                  din_sof,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  misalign,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  sipo_state_e           state;
  logic [CW-1:0]         cnt;
  // Bit 0 of the shift register is always shifted out before a word completes, so it is not stored.
  logic [DATA_WIDTH-1:1] sreg;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  word_done;

  assign shifted   = {din, sreg};
  assign word_done = (state == ASSEM) && din_vld && !din_sof && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= HUNT;
      cnt      <= '0;
      sreg     <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (din_vld) begin
        case (state)
          HUNT: begin
            if (din_sof) begin
              sreg  <= shifted[DATA_WIDTH-1:1];
              cnt   <= ONE;
              state <= ASSEM;
            end
          end
          ASSEM: begin
            sreg <= shifted[DATA_WIDTH-1:1];
            // A start marker anywhere but a word boundary throws away the partial word.
            if (din_sof) begin
              cnt      <= ONE;
              misalign <= (cnt != '0);
            end else if (cnt == LAST) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  sipo_out_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_slot (
    .clk       (clk),
    .resetn    (resetn),
    .load      (word_done),
    .word      (shifted),
    .dout_ready(dout_ready),
    .ovf_clr   (ovf_clr),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overflow  (overflow)
  );

endmodule
